// File: rtl/mem_ctrl.sv
// mem_ctrl: byte-serial RAM controller shared by instruction fetch and the
// MEM stage. Loads, stores and fetches are split into 1/2/4 byte RAM
// accesses; the RAM returns read data one cycle after the address.
module mem_ctrl (
   input  logic        clk_in,
   input  logic        rst_in,
   input  logic        rdy_in,
   input  logic        if_req,
   input  logic [31:0] if_addr,
   output logic        if_done,
   output logic [31:0] if_inst,
   input  logic        mem_req,
   input  logic        mem_wr_req,
   input  logic [1:0]  mem_len,
   input  logic [31:0] mem_addr,
   input  logic [31:0] mem_wdata,
   output logic        mem_done,
   output logic [31:0] mem_rdata,
   input  logic        flush_in,
   input  logic [7:0]  ram_din,
   output logic [7:0]  ram_dout,
   output logic [31:0] ram_a,
   output logic        ram_wr
);

   localparam int unsigned AW = 32;
   localparam int unsigned DW = 32;
   localparam int unsigned BW = 8;
   localparam int unsigned CW = 3;

   typedef enum logic [1:0] {
      IDLE,
      IF_RD,
      MEM_RD,
      MEM_WR
   } state_e;

   state_e        state_q, state_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic [CW-1:0] nbytes_q, nbytes_d;
   logic [AW-1:0] addr_q, addr_d;
   logic [AW-1:0] ram_a_q, ram_a_d;
   logic [DW-1:0] wdata_q, wdata_d;
   logic [DW-1:0] data_q, data_d;
   logic [DW-1:0] if_inst_q, if_inst_d;
   logic [DW-1:0] mem_rdata_q, mem_rdata_d;

   logic [AW-1:0] issue_addr;
   logic [DW-1:0] capt_word;
   logic [DW-1:0] rd_word;

   // Address of the byte issued this cycle; cnt_q counts bytes already issued.
   assign issue_addr = addr_q + AW'(cnt_q);

   // Byte arriving now belongs to the previously issued address (cnt_q - 1).
   assign capt_word = data_q | (DW'(ram_din) << {2'(cnt_q - CW'(1)), 3'b000});

   // Completed read word: collected bytes plus the final byte still on ram_din.
   assign rd_word = data_q | (DW'(ram_din) << {2'(nbytes_q - CW'(1)), 3'b000});

   // State and datapath registers; rdy_in gating is folded into the _d logic.
   always_ff @(posedge clk_in or posedge rst_in) begin
      if (rst_in) begin
         state_q     <= IDLE;
         cnt_q       <= '0;
         nbytes_q    <= '0;
         addr_q      <= '0;
         ram_a_q     <= '0;
         wdata_q     <= '0;
         data_q      <= '0;
         if_inst_q   <= '0;
         mem_rdata_q <= '0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         nbytes_q    <= nbytes_d;
         addr_q      <= addr_d;
         ram_a_q     <= ram_a_d;
         wdata_q     <= wdata_d;
         data_q      <= data_d;
         if_inst_q   <= if_inst_d;
         mem_rdata_q <= mem_rdata_d;
      end
   end

   // Arbitration, byte sequencing and completion; a paused cycle keeps all state.
   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      nbytes_d    = nbytes_q;
      addr_d      = addr_q;
      ram_a_d     = ram_a_q;
      wdata_d     = wdata_q;
      data_d      = data_q;
      if_inst_d   = if_inst_q;
      mem_rdata_d = mem_rdata_q;
      if_done     = 1'b0;
      mem_done    = 1'b0;
      if_inst     = if_inst_q;
      mem_rdata   = mem_rdata_q;
      ram_a       = ram_a_q;
      ram_dout    = '0;
      ram_wr      = 1'b0;

      if (rdy_in) begin
         case (state_q)
            IDLE: begin
               if (mem_req) begin
                  state_d = mem_wr_req ? MEM_WR : MEM_RD;
                  addr_d  = mem_addr;
                  wdata_d = mem_wdata;
                  cnt_d   = '0;
                  data_d  = '0;
                  case (mem_len)
                     2'b00:   nbytes_d = CW'(1);
                     2'b01:   nbytes_d = CW'(2);
                     default: nbytes_d = CW'(4);
                  endcase
               end else if (if_req && !flush_in) begin
                  state_d  = IF_RD;
                  addr_d   = if_addr;
                  cnt_d    = '0;
                  data_d   = '0;
                  nbytes_d = CW'(4);
               end
            end

            IF_RD, MEM_RD: begin
               if ((state_q == IF_RD) && flush_in) begin
                  state_d = IDLE;
               end else if (cnt_q == nbytes_q) begin
                  state_d = IDLE;
                  if (state_q == IF_RD) begin
                     if_done   = 1'b1;
                     if_inst   = rd_word;
                     if_inst_d = rd_word;
                  end else begin
                     mem_done    = 1'b1;
                     mem_rdata   = rd_word;
                     mem_rdata_d = rd_word;
                  end
               end else begin
                  ram_a   = issue_addr;
                  ram_a_d = issue_addr;
                  cnt_d   = cnt_q + CW'(1);
                  if (cnt_q != '0) begin
                     data_d = capt_word;
                  end
               end
            end

            MEM_WR: begin
               if (cnt_q == nbytes_q) begin
                  state_d  = IDLE;
                  mem_done = 1'b1;
               end else begin
                  ram_a    = issue_addr;
                  ram_a_d  = issue_addr;
                  ram_dout = BW'(wdata_q >> {cnt_q[1:0], 3'b000});
                  ram_wr   = 1'b1;
                  cnt_d    = cnt_q + CW'(1);
               end
            end

            default: state_d = IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_mem_ctrl.sv
// tb_mem_ctrl: randomized and directed checks of mem_ctrl against a
// byte-addressed RAM model and transaction-level expectations.
module tb_mem_ctrl;

   localparam int K_IF = 0;
   localparam int K_LD = 1;
   localparam int K_ST = 2;

   logic        clk_in     = 1'b0;
   logic        rst_in     = 1'b1;
   logic        rdy_in     = 1'b1;
   logic        if_req     = 1'b0;
   logic [31:0] if_addr    = '0;
   logic        if_done;
   logic [31:0] if_inst;
   logic        mem_req    = 1'b0;
   logic        mem_wr_req = 1'b0;
   logic [1:0]  mem_len    = '0;
   logic [31:0] mem_addr   = '0;
   logic [31:0] mem_wdata  = '0;
   logic        mem_done;
   logic [31:0] mem_rdata;
   logic        flush_in   = 1'b0;
   logic [7:0]  ram_din    = '0;
   logic [7:0]  ram_dout;
   logic [31:0] ram_a;
   logic        ram_wr;

   int checks = 0;
   int errors = 0;

   mem_ctrl dut (
      .clk_in     (clk_in),
      .rst_in     (rst_in),
      .rdy_in     (rdy_in),
      .if_req     (if_req),
      .if_addr    (if_addr),
      .if_done    (if_done),
      .if_inst    (if_inst),
      .mem_req    (mem_req),
      .mem_wr_req (mem_wr_req),
      .mem_len    (mem_len),
      .mem_addr   (mem_addr),
      .mem_wdata  (mem_wdata),
      .mem_done   (mem_done),
      .mem_rdata  (mem_rdata),
      .flush_in   (flush_in),
      .ram_din    (ram_din),
      .ram_dout   (ram_dout),
      .ram_a      (ram_a),
      .ram_wr     (ram_wr)
   );

   always #5 clk_in = ~clk_in;

   // Sparse byte RAM: synchronous read, write when ram_wr is high.
   logic [7:0] mem [bit [31:0]];

   function automatic logic [7:0] mem_rd(input logic [31:0] a);
      if (mem.exists(a)) return mem[a];
      return 8'h00;
   endfunction

   always @(posedge clk_in) begin
      ram_din <= mem_rd(ram_a);
      if (ram_wr === 1'b1) mem[ram_a] = ram_dout;
   end

   function automatic int nbytes(input logic [1:0] len);
      case (len)
         2'b00:   return 1;
         2'b01:   return 2;
         default: return 4;
      endcase
   endfunction

   // Issue one transaction and follow it cycle by cycle against the model:
   // the j-th unpaused cycle after acceptance drives byte j-1, the one after
   // the last byte is the completion cycle; paused cycles hold ram_a, no write.
   task automatic run_txn(input int kind, input logic [1:0] len, input logic [31:0] addr,
                          input logic [31:0] wdata, input int pause_at, input int pause_len,
                          input int flush_at, input int max_c,
                          output int done_cyc, output logic [31:0] data);
      int          n;
      int          j;
      bit          paused;
      bit          hold_ok;
      bit          flushed;
      logic [31:0] last_a;
      logic [31:0] exp_a;
      logic [7:0]  exp_b;
      n          = (kind == K_IF) ? 4 : nbytes(len);
      if_req     = (kind == K_IF);
      if_addr    = addr;
      mem_req    = (kind != K_IF);
      mem_wr_req = (kind == K_ST);
      mem_len    = len;
      mem_addr   = addr;
      mem_wdata  = wdata;
      rdy_in     = 1'b1;
      flush_in   = 1'b0;
      @(posedge clk_in);
      #1;
      if_req   = 1'b0;
      mem_req  = 1'b0;
      done_cyc = 0;
      data     = '0;
      j        = 0;
      hold_ok  = 0;
      flushed  = 0;
      last_a   = '0;
      for (int c = 1; c <= max_c; c++) begin
         paused   = (c >= pause_at) && (c < pause_at + pause_len);
         rdy_in   = !paused;
         flush_in = (c == flush_at);
         if (kind == K_IF && flush_at > 0 && c >= flush_at) flushed = 1;
         @(negedge clk_in);
         checks++;
         if (if_done === 1'b1 && mem_done === 1'b1) begin
            errors++;
            $display("FAIL both_done cycle=%0d got if_done=1 mem_done=1 exp not both", c);
         end
         checks++;
         if (((kind == K_IF) ? mem_done : if_done) !== 1'b0) begin
            errors++;
            $display("FAIL wrong_done cycle=%0d kind=%0d got if_done=%b mem_done=%b", c, kind, if_done, mem_done);
         end
         if (paused || flushed) begin
            checks++;
            if (ram_wr !== 1'b0) begin
               errors++;
               $display("FAIL idle_wr cycle=%0d got ram_wr=%b exp 0", c, ram_wr);
            end
            if (paused && hold_ok) begin
               checks++;
               if (ram_a !== last_a) begin
                  errors++;
                  $display("FAIL hold_addr cycle=%0d got %h exp %h", c, ram_a, last_a);
               end
            end
         end else begin
            j++;
            if (j <= n) begin
               exp_a = addr + 32'(j - 1);
               checks++;
               if (ram_a !== exp_a) begin
                  errors++;
                  $display("FAIL ram_a cycle=%0d got %h exp %h", c, ram_a, exp_a);
               end
               checks++;
               if (ram_wr !== (kind == K_ST)) begin
                  errors++;
                  $display("FAIL ram_wr cycle=%0d got %b exp %b", c, ram_wr, (kind == K_ST));
               end
               if (kind == K_ST) begin
                  exp_b = 8'(wdata >> (8 * (j - 1)));
                  checks++;
                  if (ram_dout !== exp_b) begin
                     errors++;
                     $display("FAIL ram_dout cycle=%0d got %h exp %h", c, ram_dout, exp_b);
                  end
               end
               last_a  = exp_a;
               hold_ok = 1;
            end else begin
               hold_ok = 0;
               checks++;
               if (ram_wr !== 1'b0) begin
                  errors++;
                  $display("FAIL done_wr cycle=%0d got ram_wr=%b exp 0", c, ram_wr);
               end
            end
         end
         if (((kind == K_IF) ? if_done : mem_done) === 1'b1) begin
            done_cyc = c;
            data     = (kind == K_IF) ? if_inst : mem_rdata;
         end
         @(posedge clk_in);
         #1;
         if (done_cyc != 0) break;
      end
      rdy_in   = 1'b1;
      flush_in = 1'b0;
   endtask

   task automatic test_reset();
      @(negedge clk_in);
      checks++; if (if_done !== 1'b0)    begin errors++; $display("FAIL rst_if_done got %b exp 0", if_done); end
      checks++; if (mem_done !== 1'b0)   begin errors++; $display("FAIL rst_mem_done got %b exp 0", mem_done); end
      checks++; if (if_inst !== 32'h0)   begin errors++; $display("FAIL rst_if_inst got %h exp 0", if_inst); end
      checks++; if (mem_rdata !== 32'h0) begin errors++; $display("FAIL rst_mem_rdata got %h exp 0", mem_rdata); end
      checks++; if (ram_a !== 32'h0)     begin errors++; $display("FAIL rst_ram_a got %h exp 0", ram_a); end
      checks++; if (ram_dout !== 8'h0)   begin errors++; $display("FAIL rst_ram_dout got %h exp 0", ram_dout); end
      checks++; if (ram_wr !== 1'b0)     begin errors++; $display("FAIL rst_ram_wr got %b exp 0", ram_wr); end
      @(posedge clk_in);
      #1;
      rst_in = 1'b0;
   endtask

   task automatic test_fetch();
      int          dc;
      logic [31:0] d;
      mem[32'h100] = 8'h13;
      mem[32'h101] = 8'h00;
      mem[32'h102] = 8'h00;
      mem[32'h103] = 8'h00;
      run_txn(K_IF, 2'b10, 32'h100, '0, 0, 0, 0, 10, dc, d);
      checks++; if (dc != 5) begin errors++; $display("FAIL fetch_latency got %0d exp 5", dc); end
      checks++; if (d !== 32'h13) begin errors++; $display("FAIL fetch_data got %h exp 00000013", d); end
      @(negedge clk_in);
      checks++;
      if (if_done !== 1'b0 || if_inst !== 32'h13) begin
         errors++;
         $display("FAIL fetch_hold got done=%b inst=%h exp done=0 inst=00000013", if_done, if_inst);
      end
      @(posedge clk_in);
      #1;
   endtask

   task automatic test_random_loads();
      int          dc, n, pa, pl;
      logic [1:0]  len;
      logic [31:0] addr, expv, d;
      logic [7:0]  bv;
      for (int i = 0; i < 12; i++) begin
         len  = 2'($urandom_range(0, 3));
         n    = nbytes(len);
         addr = (i == 0) ? 32'hFFFF_FFFF : (i == 1) ? 32'hFFFF_FFFE : 32'($urandom);
         expv = '0;
         for (int b = 0; b < 4; b++) begin
            bv = 8'($urandom_range(1, 255));
            mem[addr + 32'(b)] = bv;
            if (b < n) expv = expv | (32'(bv) << (8 * b));
         end
         pa = 0;
         pl = 0;
         if ($urandom_range(0, 1) == 1) begin
            pa = $urandom_range(1, n + 1);
            pl = $urandom_range(1, 3);
         end
         run_txn(K_LD, len, addr, '0, pa, pl, 0, 20, dc, d);
         checks++;
         if (dc != n + 1 + pl) begin
            errors++;
            $display("FAIL load_latency i=%0d got %0d exp %0d", i, dc, n + 1 + pl);
         end
         checks++;
         if (d !== expv) begin
            errors++;
            $display("FAIL load_data i=%0d addr=%h len=%0d got %h exp %h", i, addr, len, d, expv);
         end
         @(negedge clk_in);
         checks++;
         if (mem_done !== 1'b0 || mem_rdata !== expv) begin
            errors++;
            $display("FAIL load_hold i=%0d got done=%b data=%h exp done=0 data=%h", i, mem_done, mem_rdata, expv);
         end
         @(posedge clk_in);
         #1;
      end
   endtask

   task automatic test_random_stores();
      int          dc, n, pa, pl;
      logic [1:0]  len;
      logic [31:0] addr, wd, d;
      logic [7:0]  got, expb;
      for (int i = 0; i < 8; i++) begin
         if (i == 0) begin
            len  = 2'b10;
            addr = 32'hFFFF_FFFE;
            wd   = 32'hDEAD_BEEF;
         end else begin
            len  = 2'($urandom_range(0, 3));
            addr = 32'($urandom);
            wd   = 32'($urandom);
         end
         n = nbytes(len);
         for (int b = 0; b <= n; b++) mem[addr + 32'(b)] = 8'h5A;
         pa = 0;
         pl = 0;
         if (i != 0 && $urandom_range(0, 1) == 1) begin
            pa = $urandom_range(1, n + 1);
            pl = $urandom_range(1, 3);
         end
         run_txn(K_ST, len, addr, wd, pa, pl, 0, 20, dc, d);
         checks++;
         if (dc != n + 1 + pl) begin
            errors++;
            $display("FAIL store_latency i=%0d got %0d exp %0d", i, dc, n + 1 + pl);
         end
         for (int b = 0; b <= n; b++) begin
            got  = mem_rd(addr + 32'(b));
            expb = (b < n) ? 8'(wd >> (8 * b)) : 8'h5A;
            checks++;
            if (got !== expb) begin
               errors++;
               $display("FAIL store_ram i=%0d byte=%0d got %h exp %h", i, b, got, expb);
            end
         end
      end
   endtask

   task automatic test_priority();
      int          mem_dc, if_dc, n_md;
      logic [31:0] a1, a5, md, id;
      mem[32'h2000] = 8'h34;
      mem[32'h2001] = 8'h12;
      mem[32'h2002] = 8'h99;
      mem[32'h2003] = 8'h77;
      mem[32'h3000] = 8'h93;
      mem[32'h3001] = 8'h00;
      mem[32'h3002] = 8'h10;
      mem[32'h3003] = 8'h00;
      mem_req    = 1'b1;
      mem_wr_req = 1'b0;
      mem_len    = 2'b01;
      mem_addr   = 32'h2000;
      if_req     = 1'b1;
      if_addr    = 32'h3000;
      @(posedge clk_in);
      #1;
      mem_req = 1'b0;
      mem_dc  = 0;
      if_dc   = 0;
      n_md    = 0;
      a1      = '0;
      a5      = '0;
      md      = '0;
      id      = '0;
      for (int c = 1; c <= 11; c++) begin
         if (c == 5) if_req = 1'b0;
         @(negedge clk_in);
         if (c == 1) a1 = ram_a;
         if (c == 5) a5 = ram_a;
         checks++;
         if (if_done === 1'b1 && mem_done === 1'b1) begin
            errors++;
            $display("FAIL prio_both_done cycle=%0d got both high exp exclusive", c);
         end
         if (mem_done === 1'b1) begin
            n_md++;
            if (mem_dc == 0) begin mem_dc = c; md = mem_rdata; end
         end
         if (if_done === 1'b1 && if_dc == 0) begin if_dc = c; id = if_inst; end
         @(posedge clk_in);
         #1;
      end
      checks++; if (a1 !== 32'h2000) begin errors++; $display("FAIL prio_first_addr got %h exp 00002000", a1); end
      checks++; if (mem_dc != 3) begin errors++; $display("FAIL prio_mem_latency got %0d exp 3", mem_dc); end
      checks++; if (n_md != 1) begin errors++; $display("FAIL prio_mem_pulses got %0d exp 1", n_md); end
      checks++; if (md !== 32'h0000_1234) begin errors++; $display("FAIL prio_mem_data got %h exp 00001234", md); end
      checks++; if (a5 !== 32'h3000) begin errors++; $display("FAIL prio_if_start got %h exp 00003000", a5); end
      checks++; if (if_dc != 9) begin errors++; $display("FAIL prio_if_latency got %0d exp 9", if_dc); end
      checks++; if (id !== 32'h0010_0093) begin errors++; $display("FAIL prio_if_data got %h exp 00100093", id); end
   endtask

   task automatic test_flush();
      int          dc;
      logic [31:0] d;
      mem[32'h600] = 8'h11; mem[32'h601] = 8'h22; mem[32'h602] = 8'h33; mem[32'h603] = 8'h44;
      mem[32'h700] = 8'hA1; mem[32'h701] = 8'hB2; mem[32'h702] = 8'hC3; mem[32'h703] = 8'hD4;
      mem[32'h800] = 8'h01; mem[32'h801] = 8'h02; mem[32'h802] = 8'h03; mem[32'h803] = 8'h04;
      run_txn(K_IF, 2'b10, 32'h600, '0, 0, 0, 3, 6, dc, d);
      checks++; if (dc != 0) begin errors++; $display("FAIL flush_mid got done at %0d exp none", dc); end
      run_txn(K_IF, 2'b10, 32'h600, '0, 0, 0, 0, 10, dc, d);
      checks++; if (dc != 5) begin errors++; $display("FAIL flush_refetch_latency got %0d exp 5", dc); end
      checks++; if (d !== 32'h4433_2211) begin errors++; $display("FAIL flush_refetch_data got %h exp 44332211", d); end
      run_txn(K_IF, 2'b10, 32'h700, '0, 0, 0, 5, 7, dc, d);
      checks++; if (dc != 0) begin errors++; $display("FAIL flush_at_done got done at %0d exp none", dc); end
      checks++; if (if_inst !== 32'h4433_2211) begin errors++; $display("FAIL flush_inst_hold got %h exp 44332211", if_inst); end
      if_req   = 1'b1;
      if_addr  = 32'h700;
      flush_in = 1'b1;
      @(posedge clk_in);
      #1;
      flush_in = 1'b0;
      run_txn(K_IF, 2'b10, 32'h700, '0, 0, 0, 0, 10, dc, d);
      checks++; if (dc != 5) begin errors++; $display("FAIL flush_idle_latency got %0d exp 5", dc); end
      checks++; if (d !== 32'hD4C3_B2A1) begin errors++; $display("FAIL flush_idle_data got %h exp d4c3b2a1", d); end
      run_txn(K_LD, 2'b10, 32'h800, '0, 0, 0, 2, 10, dc, d);
      checks++; if (dc != 5) begin errors++; $display("FAIL flush_load_latency got %0d exp 5", dc); end
      checks++; if (d !== 32'h0403_0201) begin errors++; $display("FAIL flush_load_data got %h exp 04030201", d); end
   endtask

   task automatic test_pause();
      int          dc;
      logic [31:0] d;
      mem[32'h5000] = 8'hEF; mem[32'h5001] = 8'hCD; mem[32'h5002] = 8'hAB; mem[32'h5003] = 8'h89;
      run_txn(K_LD, 2'b10, 32'h5000, '0, 3, 3, 0, 20, dc, d);
      checks++; if (dc != 8) begin errors++; $display("FAIL pause_latency got %0d exp 8", dc); end
      checks++; if (d !== 32'h89AB_CDEF) begin errors++; $display("FAIL pause_data got %h exp 89abcdef", d); end
   endtask

   task automatic test_reset_mid_store();
      int          dc, nd;
      logic [31:0] d;
      for (int b = 0; b < 4; b++) mem[32'h4000 + 32'(b)] = 8'h00;
      mem_req    = 1'b1;
      mem_wr_req = 1'b1;
      mem_len    = 2'b10;
      mem_addr   = 32'h4000;
      mem_wdata  = 32'hCAFE_F00D;
      @(posedge clk_in);
      #1;
      mem_req = 1'b0;
      @(posedge clk_in);
      #1;
      @(posedge clk_in);
      #3;
      rst_in = 1'b1;
      #1;
      checks++; if (ram_wr !== 1'b0)     begin errors++; $display("FAIL mrst_ram_wr got %b exp 0", ram_wr); end
      checks++; if (ram_a !== 32'h0)     begin errors++; $display("FAIL mrst_ram_a got %h exp 0", ram_a); end
      checks++; if (ram_dout !== 8'h0)   begin errors++; $display("FAIL mrst_ram_dout got %h exp 0", ram_dout); end
      checks++; if (mem_done !== 1'b0)   begin errors++; $display("FAIL mrst_mem_done got %b exp 0", mem_done); end
      checks++; if (mem_rdata !== 32'h0) begin errors++; $display("FAIL mrst_mem_rdata got %h exp 0", mem_rdata); end
      checks++; if (if_inst !== 32'h0)   begin errors++; $display("FAIL mrst_if_inst got %h exp 0", if_inst); end
      @(posedge clk_in);
      #1;
      rst_in = 1'b0;
      nd = 0;
      for (int c = 0; c < 6; c++) begin
         @(negedge clk_in);
         if (mem_done === 1'b1 || if_done === 1'b1) nd++;
         @(posedge clk_in);
         #1;
      end
      checks++; if (nd != 0) begin errors++; $display("FAIL mrst_done_pulses got %0d exp 0", nd); end
      checks++; if (mem_rd(32'h4000) !== 8'h0D) begin errors++; $display("FAIL mrst_byte0 got %h exp 0d", mem_rd(32'h4000)); end
      checks++; if (mem_rd(32'h4001) !== 8'hF0) begin errors++; $display("FAIL mrst_byte1 got %h exp f0", mem_rd(32'h4001)); end
      checks++; if (mem_rd(32'h4002) !== 8'h00) begin errors++; $display("FAIL mrst_byte2 got %h exp 00", mem_rd(32'h4002)); end
      checks++; if (mem_rd(32'h4003) !== 8'h00) begin errors++; $display("FAIL mrst_byte3 got %h exp 00", mem_rd(32'h4003)); end
      run_txn(K_IF, 2'b10, 32'h100, '0, 0, 0, 0, 10, dc, d);
      checks++; if (dc != 5) begin errors++; $display("FAIL mrst_fetch_latency got %0d exp 5", dc); end
      checks++; if (d !== 32'h13) begin errors++; $display("FAIL mrst_fetch_data got %h exp 00000013", d); end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog expired checks=%0d errors=%0d", checks, errors);
      $fatal(1, "watchdog");
   end

   initial begin
      test_reset();
      test_fetch();
      test_random_loads();
      test_random_stores();
      test_priority();
      test_flush();
      test_pause();
      test_reset_mid_store();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/mem_ctrl.md
MEM_CTRL -- requirements
Module: mem_ctrl

Interface
REQ-001 clk_in  input  1  system clock; all state updates on rising edge.
REQ-002 rst_in  input  1  reset, asynchronous, active-high.
REQ-003 rdy_in  input  1  global ready; low = pause.
REQ-004 if_req  input  1  instruction-fetch request (word read).
REQ-005 if_addr  input  32  fetch address.
REQ-006 if_done  output  1  one-cycle pulse; if_inst valid.
REQ-007 if_inst  output  32  fetched word, little-endian.
REQ-008 mem_req  input  1  load/store request from MEM stage.
REQ-009 mem_wr_req  input  1  1 = store, 0 = load; sampled with mem_req.
REQ-010 mem_len  input  2  00 byte, 01 half, 10 word, 11 treated as word.
REQ-011 mem_addr  input  32  data address.
REQ-012 mem_wdata  input  32  store data; low bytes used first.
REQ-013 mem_done  output  1  one-cycle pulse; load or store complete.
REQ-014 mem_rdata  output  32  raw load data, zero-filled above mem_len; no sign extension.
REQ-015 flush_in  input  1  branch taken in EX; aborts an in-flight fetch.
REQ-016 ram_din  input  8  byte from RAM.
REQ-017 ram_dout  output  8  byte to RAM.
REQ-018 ram_a  output  32  RAM byte address.
REQ-019 ram_wr  output  1  1 = write ram_dout to ram_a this cycle.

Function
REQ-020 States IDLE, IF_RD, MEM_RD, MEM_WR. Registered byte counter cnt (0..4). Byte count N = 1/2/4 per mem_len; IF always N=4.
REQ-021 Arbitration in IDLE only. Priority: mem_req over if_req. No preemption once a transaction starts.
REQ-022 On the accepting edge, latch address, N, wdata and kind. Move to IF_RD, MEM_RD or MEM_WR with cnt=0.
REQ-023 Read: during busy cycle k (k=1..N) drive ram_a = addr+k-1 and ram_wr=0. RAM returns the byte on ram_din one cycle later. Capture byte k-1 at the end of cycle k+1.
REQ-024 Read completion: done pulses high for exactly one cycle, N+1 cycles after the accepting edge, with data valid in the same cycle. Return to IDLE on that edge.
REQ-025 Write: during busy cycle k (k=1..N) drive ram_a = addr+k-1, ram_dout = wdata byte k-1, ram_wr=1. mem_done pulses in cycle N+1. Return to IDLE.
REQ-026 Address arithmetic is 32-bit modulo 2^32. 0xFFFFFFFF+1 wraps to 0x00000000.
REQ-027 In IDLE, and in any cycle where done is high, ram_wr=0 and no request is accepted. This gives a one-cycle turnaround so a requester can drop req.
REQ-028 done and data outputs hold their previous data value and done=0 outside completion cycles. mem_rdata and if_inst change only at completion.
REQ-029 flush_in high in IF_RD: go to IDLE at the next edge; if_done is never asserted for that fetch, even if it would complete on the same edge.
REQ-030 flush_in high in IDLE: if_req is not accepted that cycle; mem_req is still accepted.
REQ-031 flush_in has no effect on MEM_RD or MEM_WR; stores always finish.
REQ-032 rdy_in low: no register updates, ram_wr=0, ram_a holds its value. On resume the current byte is re-issued.
REQ-033 if_done and mem_done are never high in the same cycle.

Reset
REQ-034 rst_in high forces, immediately and regardless of clk_in: state IDLE, cnt 0, if_done 0, mem_done 0, if_inst 0, mem_rdata 0, ram_a 0, ram_dout 0, ram_wr 0.
REQ-035 Reset mid-transaction abandons the transaction with no done pulse. A partially written store is not rolled back.

Verification
REQ-036 if_req, if_addr=0x100, RAM[0x100..0x103]=13 00 00 00 -> ram_a 0x100..0x103 on consecutive cycles; if_done once at cycle 5; if_inst=0x00000013.
REQ-037 mem_req and if_req asserted on the same edge, load half at 0x2000 -> MEM served first (mem_rdata=0x0000xxxx, upper bytes 0). IF starts after the turnaround cycle.
REQ-038 Store word 0xDEADBEEF at 0xFFFFFFFE -> writes EF,BE,AD,DE to 0xFFFFFFFE, 0xFFFFFFFF, 0x0, 0x1 with ram_wr=1; mem_done at cycle 5.
REQ-039 flush_in pulsed in cycle 3 of a fetch -> IDLE next cycle; no if_done; a new fetch is accepted afterwards.
REQ-040 rdy_in low for 3 cycles mid-load -> ram_wr=0 and ram_a held; final data is correct; done is delayed by exactly 3 cycles.
REQ-041 rst_in asserted mid-store after byte 2 -> all outputs 0 immediately; no mem_done; controller accepts if_req after release.
